// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants and types for the data-memory arbiter.
//   - FSM state encoding (legacy-compatible plain localparams)
//   - requester port indices
//   - latched command and captured response record types
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic P_MEM = 1'b0;  // pipeline MEM stage
  localparam logic P_DBG = 1'b1;  // debug / loader (DMA)

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester handshakes and the single-port
// memory pins that the arbiter owns.
//   slave  : arbiter view (requests and mem_rdata in; acks, read data, errors,
//            stall and memory controls out)
//   master : requester/memory view (the mirror image)
interface dmem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        err0;
  logic        err1;
  logic        stall0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, err0, err1, stall0,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, err0, err1, stall0,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: combinational two-way request picker.
//   req_i        : raw requests {port1, port0}
//   mask_i       : ports excluded this cycle (e.g. the one being acked)
//   last_grant_i : most recently granted port (round-robin pointer)
//   grant_valid_o: some unmasked port is requesting
//   grant_idx_o  : winning port index
module dmem_arb_rr
  import dmem_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0  // 1: port 0 always wins a tie
) (
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  logic [1:0] eff_req;

  always_comb begin
    eff_req       = req_i & ~mask_i;
    grant_valid_o = |eff_req;
    grant_idx_o   = P_MEM;
    if (eff_req == 2'b10) begin
      grant_idx_o = P_DBG;
    end else if (eff_req == 2'b11) begin
      // Tie: fixed priority favours port 0, otherwise serve the port not granted last.
      grant_idx_o = FIXED_PRI ? P_MEM : ~last_grant_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (port 0) and the debug/loader port (port 1), one word at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave -- requester req/we/addr/wdata in,
//                ack/rdata/err out, stall0 out, memory addr/wdata/we/re out,
//                mem_rdata in
// Each access runs IDLE -> ACCESS -> RESP; from RESP the other port can be
// granted directly, giving back-to-back service under alternating contention.
// Addresses >= DEPTH complete with err set and never write the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter bit          FIXED_PRI = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  cmd_t       cmd_q, cmd_d;
  resp_t      resp_q, resp_d;

  logic [1:0] req_vec;
  logic [1:0] mask;
  logic       grant_valid;
  logic       grant_idx;
  logic       in_range;
  logic       in_access;
  logic       in_resp;

  assign req_vec   = {bus.req1, bus.req0};
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);
  assign in_range  = (cmd_q.addr < DEPTH);

  // The port being acked still holds its stale req this cycle; keep it out of the pick.
  assign mask = in_resp ? ((cmd_q.port == P_DBG) ? 2'b10 : 2'b01) : 2'b00;

  dmem_arb_rr #(
    .FIXED_PRI(FIXED_PRI)
  ) u_pick (
    .req_i        (req_vec),
    .mask_i       (mask),
    .last_grant_i (last_grant_q),
    .grant_valid_o(grant_valid),
    .grant_idx_o  (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    resp_d       = resp_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_valid) begin
          cmd_d.port   = grant_idx;
          cmd_d.we     = (grant_idx == P_DBG) ? bus.we1 : bus.we0;
          cmd_d.addr   = (grant_idx == P_DBG) ? bus.addr1 : bus.addr0;
          cmd_d.wdata  = (grant_idx == P_DBG) ? bus.wdata1 : bus.wdata0;
          last_grant_d = grant_idx;
          state_d      = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Writes and out-of-range reads return zero data.
        resp_d.data = (!cmd_q.we && in_range) ? bus.mem_rdata : 32'd0;
        resp_d.err  = !in_range;
        state_d     = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= P_DBG;  // so port 0 wins the first tie
      cmd_q        <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      resp_q       <= resp_d;
    end
  end

  always_comb begin
    bus.ack0   = in_resp && (cmd_q.port == P_MEM);
    bus.ack1   = in_resp && (cmd_q.port == P_DBG);
    bus.rdata0 = bus.ack0 ? resp_q.data : 32'd0;
    bus.rdata1 = bus.ack1 ? resp_q.data : 32'd0;
    bus.err0   = bus.ack0 && resp_q.err;
    bus.err1   = bus.ack1 && resp_q.err;
    bus.stall0 = bus.req0 && !bus.ack0;
  end

  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.mem_we    = in_access && cmd_q.we && in_range;
  assign bus.mem_re    = in_access && !cmd_q.we;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if bus_a ();
  dmem_arbiter_if bus_b ();

  dmem_arbiter #(.DEPTH(128), .FIXED_PRI(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dmem_arbiter #(.DEPTH(128), .FIXED_PRI(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Requester drive, indexed [dut][port].
  logic        req_v   [2][2];
  logic        we_v    [2][2];
  logic [31:0] addr_v  [2][2];
  logic [31:0] wdata_v [2][2];
  logic        ack_v   [2][2];

  assign bus_a.req0 = req_v[0][0];   assign bus_a.req1 = req_v[0][1];
  assign bus_a.we0  = we_v[0][0];    assign bus_a.we1  = we_v[0][1];
  assign bus_a.addr0 = addr_v[0][0]; assign bus_a.addr1 = addr_v[0][1];
  assign bus_a.wdata0 = wdata_v[0][0]; assign bus_a.wdata1 = wdata_v[0][1];
  assign bus_b.req0 = req_v[1][0];   assign bus_b.req1 = req_v[1][1];
  assign bus_b.we0  = we_v[1][0];    assign bus_b.we1  = we_v[1][1];
  assign bus_b.addr0 = addr_v[1][0]; assign bus_b.addr1 = addr_v[1][1];
  assign bus_b.wdata0 = wdata_v[1][0]; assign bus_b.wdata1 = wdata_v[1][1];
  assign ack_v[0][0] = bus_a.ack0;   assign ack_v[0][1] = bus_a.ack1;
  assign ack_v[1][0] = bus_b.ack0;   assign ack_v[1][1] = bus_b.ack1;

  // Memory models: async read, write on rising edge; out-of-range reads return junk.
  logic [31:0] mem [2][128];
  always @(posedge clk) if (bus_a.mem_we) mem[0][bus_a.mem_addr[6:0]] <= bus_a.mem_wdata;
  always @(posedge clk) if (bus_b.mem_we) mem[1][bus_b.mem_addr[6:0]] <= bus_b.mem_wdata;
  assign bus_a.mem_rdata = (bus_a.mem_addr < 32'd128) ? mem[0][bus_a.mem_addr[6:0]] : 32'hBAD0BAD0;
  assign bus_b.mem_rdata = (bus_b.mem_addr < 32'd128) ? mem[1][bus_b.mem_addr[6:0]] : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard: one expected-response queue per (dut, port).
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q0[$], q1[$], q2[$], q3[$];

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int k, input string name, input logic [31:0] rd, input logic err);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s unexpected ack: got rdata %h err %b, required no ack", name, rd, err);
    end else begin
      chk({name, " rdata"}, rd, e.rdata);
      chk({name, " err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Monitor: compares every ack against the scoreboard.
  always @(negedge clk) begin
    if (bus_a.ack0) pop_chk(0, "a.p0", bus_a.rdata0, bus_a.err0);
    if (bus_a.ack1) pop_chk(1, "a.p1", bus_a.rdata1, bus_a.err1);
    if (bus_b.ack0) pop_chk(2, "b.p0", bus_b.rdata0, bus_b.err0);
    if (bus_b.ack1) pop_chk(3, "b.p1", bus_b.rdata1, bus_b.err1);
  end

  // Issue one access; call at posedge+1. Returns the cycle in which ack was seen.
  task automatic issue(input int d, input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, output int ack_cyc);
    exp_t e;
    bit   got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    push_exp(d * 2 + p, e);
    req_v[d][p]   = 1'b1;
    we_v[d][p]    = we;
    addr_v[d][p]  = addr;
    wdata_v[d][p] = wdata;
    got     = 1'b0;
    ack_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_v[d][p]) begin
        got     = 1'b1;
        ack_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout d%0d p%0d: got no ack in 20 cycles, required ack", d, p);
    end
    @(posedge clk);
    #1;
    req_v[d][p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    int t0, a1, a2, a3, b1, nwe;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req_v[d][p] = 1'b0; we_v[d][p] = 1'b0; addr_v[d][p] = '0; wdata_v[d][p] = '0;
      end
      for (int w = 0; w < 128; w++) mem[d][w] = 32'h0;
    end
    mem[0][0]  = 32'hA5A5A5A5;
    mem[0][5]  = 32'hDEADBEEF;
    mem[0][6]  = 32'h66666666;
    mem[0][7]  = 32'h77777777;
    mem[1][10] = 32'h1000000A;
    mem[1][11] = 32'h1000000B;
    mem[1][12] = 32'h1000000C;
    mem[1][20] = 32'h20000014;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst ack0", {31'd0, bus_a.ack0}, 32'd0);
    chk("rst ack1", {31'd0, bus_a.ack1}, 32'd0);
    chk("rst mem_re", {31'd0, bus_a.mem_re}, 32'd0);
    chk("rst mem_we", {31'd0, bus_a.mem_we}, 32'd0);
    chk("rst mem_addr", bus_a.mem_addr, 32'd0);
    chk("rst rdata0", bus_a.rdata0, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read of addr 5 on port 0
    t0 = cyc;
    fork
      issue(0, 0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, a1);
      begin
        @(negedge clk);
        chk("rd c0 stall0", {31'd0, bus_a.stall0}, 32'd1);
        chk("rd c0 mem_re", {31'd0, bus_a.mem_re}, 32'd0);
        @(negedge clk);
        chk("rd c1 mem_re", {31'd0, bus_a.mem_re}, 32'd1);
        chk("rd c1 mem_addr", bus_a.mem_addr, 32'd5);
        chk("rd c1 stall0", {31'd0, bus_a.stall0}, 32'd1);
        @(negedge clk);
        chk("rd c2 stall0", {31'd0, bus_a.stall0}, 32'd0);
      end
    join
    chk("rd ack cycle", a1 - t0, 32'd2);

    // Port 1 writes addr 127 then reads it back
    t0 = cyc;
    issue(0, 1, 1'b1, 32'd127, 32'h12345678, 32'd0, 1'b0, a1);
    chk("wr ack cycle", a1 - t0, 32'd2);
    issue(0, 1, 1'b0, 32'd127, 32'd0, 32'h12345678, 1'b0, a2);
    chk("wr-rd ack cycle", a2 - t0, 32'd5);

    // Out-of-range write (aliases mem[0] in the model) and read
    nwe = 0;
    fork
      issue(0, 0, 1'b1, 32'd128, 32'hCAFEF00D, 32'd0, 1'b1, a1);
      repeat (4) begin
        @(negedge clk);
        if (bus_a.mem_we) nwe++;
      end
    join
    chk("oor mem_we count", nwe, 32'd0);
    chk("oor mem[0] intact", mem[0][0], 32'hA5A5A5A5);
    issue(0, 1, 1'b0, 32'd200, 32'd0, 32'd0, 1'b1, a1);

    // Reset asserted while port 1 is in ACCESS
    req_v[0][1] = 1'b1; we_v[0][1] = 1'b0; addr_v[0][1] = 32'd6;
    @(posedge clk);
    #1;
    chk("mid-rst in access", {31'd0, bus_a.mem_re}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst mem_re", {31'd0, bus_a.mem_re}, 32'd0);
    chk("mid-rst mem_addr", bus_a.mem_addr, 32'd0);
    chk("mid-rst ack1", {31'd0, bus_a.ack1}, 32'd0);
    req_v[0][1] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin contention: port 0 first after reset, then alternating every 2 cycles
    t0 = cyc;
    fork
      begin
        issue(0, 0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, a1);
        issue(0, 0, 1'b0, 32'd127, 32'd0, 32'h12345678, 1'b0, a2);
      end
      begin
        issue(0, 1, 1'b0, 32'd6, 32'd0, 32'h66666666, 1'b0, b1);
        issue(0, 1, 1'b0, 32'd7, 32'd0, 32'h77777777, 1'b0, a3);
      end
    join
    chk("rr ack0 #1 cycle", a1 - t0, 32'd2);
    chk("rr ack1 #1 cycle", b1 - t0, 32'd4);
    chk("rr ack0 #2 cycle", a2 - t0, 32'd6);
    chk("rr ack1 #2 cycle", a3 - t0, 32'd8);

    // Fixed priority: last grant is port 0, yet port 0 still wins ties in IDLE
    issue(1, 0, 1'b0, 32'd10, 32'd0, 32'h1000000A, 1'b0, a1);
    t0 = cyc;
    fork
      begin
        issue(1, 0, 1'b0, 32'd10, 32'd0, 32'h1000000A, 1'b0, a1);
        issue(1, 0, 1'b0, 32'd11, 32'd0, 32'h1000000B, 1'b0, a2);
        issue(1, 0, 1'b0, 32'd12, 32'd0, 32'h1000000C, 1'b0, a3);
      end
      issue(1, 1, 1'b0, 32'd20, 32'd0, 32'h20000014, 1'b0, b1);
    join
    chk("fp ack0 #1 cycle", a1 - t0, 32'd2);
    chk("fp ack1 cycle", b1 - t0, 32'd4);
    chk("fp ack0 #2 cycle", a2 - t0, 32'd6);
    chk("fp ack0 #3 cycle", a3 - t0, 32'd9);

    repeat (2) @(posedge clk);
    chk("scoreboard drained", q0.size() + q1.size() + q2.size() + q3.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
